// File: rtl/alu_pkg.sv
// Opcode encoding, write-enable decode and default sizes shared by the ALU stage and register bank.
// Build with ALU_WB_MUL_EN defined to turn opcode 7 into a multiply that writes back; otherwise it is a NOP.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_PASS = 3'd6,
        OP_MUL  = 3'd7
    } alu_op_e;

    function automatic logic alu_is_write(input alu_op_e op);
`ifdef ALU_WB_MUL_EN
        return (op == op);
`else
        return (op != OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and carry/borrow for one register-register operation.
// Latency 0; no handshake, always produces a result for the presented operands.
// Opcode 7 multiplies under ALU_WB_MUL_EN, otherwise yields zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the unsigned borrow (a < b).
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef ALU_WB_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = a * b;
`endif

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
            OP_SUB:  begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << b[SW-1:0];
            OP_PASS: result = a;
            OP_MUL: begin
`ifdef ALU_WB_MUL_EN
                result = prod[WIDTH-1:0];
                carry  = |prod[2*WIDTH-1:WIDTH];
`else
                result = '0;
`endif
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage with operand forwarding from a one-entry writeback register (ALU_WB_MUL_EN enables MUL).
// Latency 1 cycle accept-to-res_valid; full throughput when res_ready stays high.
// Backpressure: res_ready low holds the writeback register and drops in_ready.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter  int WIDTH = ALU_WIDTH,
    parameter  int DEPTH = ALU_DEPTH,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs1,
    input  logic [AW-1:0]    in_rs2,
    output logic [AW-1:0]    rf_raddr_a,
    output logic [AW-1:0]    rf_raddr_b,
    input  logic [WIDTH-1:0] rf_rdata_a,
    input  logic [WIDTH-1:0] rf_rdata_b,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic [CNT_W-1:0] retire_cnt
);

    logic             wb_valid;
    logic             wb_we;
    logic [AW-1:0]    wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             wb_carry;
    logic             wb_zero;

    alu_op_e          op;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             accept;
    logic             retire;

    assign op         = alu_op_e'(in_op);
    assign rf_raddr_a = in_rs1;
    assign rf_raddr_b = in_rs2;

    // The bank is only written on retire, so a pending result must bypass it.
    assign fwd_a = wb_valid && wb_we && (wb_rd == in_rs1);
    assign fwd_b = wb_valid && wb_we && (wb_rd == in_rs2);
    assign op_a  = fwd_a ? wb_data : rf_rdata_a;
    assign op_b  = fwd_b ? wb_data : rf_rdata_b;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .op     (op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res),
        .carry  (alu_carry)
    );

    assign in_ready = !wb_valid || res_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = wb_valid && res_ready;

    assign rf_we    = retire && wb_we;
    assign rf_waddr = wb_rd;
    assign rf_wdata = wb_data;

    assign res_valid = wb_valid;
    assign res_data  = wb_data;
    assign res_carry = wb_carry;
    assign res_zero  = wb_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_carry   <= 1'b0;
            wb_zero    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (accept) begin
                wb_valid <= 1'b1;
                wb_we    <= alu_is_write(op);
                wb_rd    <= in_rd;
                wb_data  <= alu_res;
                wb_carry <= alu_carry;
                wb_zero  <= (alu_res == '0);
            end else if (retire) begin
                wb_valid <= 1'b0;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage against a behavioural two-read/one-write register bank.
// Vector table for single ops, then hand-written back-to-back, stall, reset and opcode-7 sequences.
module tb_alu_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic [15:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_retire = 0;
    int wr_cnt = 0;

    logic [15:0] bank [8];
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;

    alu_wb_stage #(.WIDTH(16), .DEPTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_zero   (res_zero),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rdata_a = bank[rf_raddr_a];
    assign rf_rdata_b = bank[rf_raddr_b];

    always @(posedge clk) begin
        if (ld_en) bank[ld_addr] <= ld_data;
        else if (rf_we) bank[rf_waddr] <= rf_wdata;
        if (rf_we) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] data;
        logic        carry;
        logic        zero;
        logic        we;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_reg(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    // One isolated operation with res_ready held high, checked on the retire cycle and after it.
    task automatic run_vec(input vec_t v, input string tag);
        int w0;
        w0 = wr_cnt;
        drive(v.op, v.rd, v.rs1, v.rs2);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, " res_data"},  32'(res_data),  32'(v.data));
        chk({tag, " res_carry"}, 32'(res_carry), 32'(v.carry));
        chk({tag, " res_zero"},  32'(res_zero),  32'(v.zero));
        chk({tag, " rf_we"},     32'(rf_we),     32'(v.we));
        if (v.we) begin
            chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(v.rd));
            chk({tag, " rf_wdata"}, 32'(rf_wdata), 32'(v.data));
        end
        @(posedge clk); @(negedge clk);
        exp_retire++;
        chk({tag, " retire_cnt"}, 32'(retire_cnt), 32'(exp_retire));
        chk({tag, " idle"},       32'(res_valid),  32'd0);
        chk({tag, " writes"},     32'(wr_cnt),     32'(w0 + int'(v.we)));
    endtask

    initial begin
        int w0;
        vec_t v7;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        res_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        //           op     rd     rs1    rs2    data       c     z     we
        vecs[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 16'h0008, 1'b0, 1'b0, 1'b1}; // ADD 5+3
        vecs[1] = '{3'd1, 3'd5, 3'd2, 3'd1, 16'hFFFE, 1'b1, 1'b0, 1'b1}; // SUB 3-5
        vecs[2] = '{3'd4, 3'd6, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b1}; // XOR 5^5
        vecs[3] = '{3'd2, 3'd7, 3'd1, 3'd2, 16'h0001, 1'b0, 1'b0, 1'b1}; // AND 5&3
        vecs[4] = '{3'd3, 3'd7, 3'd1, 3'd2, 16'h0007, 1'b0, 1'b0, 1'b1}; // OR 5|3
        vecs[5] = '{3'd5, 3'd4, 3'd1, 3'd2, 16'h0028, 1'b0, 1'b0, 1'b1}; // SHL 5<<3
        vecs[6] = '{3'd6, 3'd0, 3'd2, 3'd1, 16'h0003, 1'b0, 1'b0, 1'b1}; // PASS r0=3
        vecs[7] = '{3'd0, 3'd6, 3'd0, 3'd0, 16'h0006, 1'b0, 1'b0, 1'b1}; // ADD r0+r0
        vecs[8] = '{3'd0, 3'd7, 3'd5, 3'd2, 16'h0001, 1'b1, 1'b0, 1'b1}; // ADD FFFE+3
        vecs[9] = '{3'd1, 3'd6, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b1}; // SUB 5-5

        @(negedge clk);
        for (int i = 0; i < 8; i++) load_reg(3'(i), 16'h0000);
        load_reg(3'd1, 16'h0005);
        load_reg(3'd2, 16'h0003);

        chk("reset res_valid",  32'(res_valid),  32'd0);
        chk("reset rf_we",      32'(rf_we),      32'd0);
        chk("reset in_ready",   32'(in_ready),   32'd1);
        chk("reset retire_cnt", 32'(retire_cnt), 32'd0);
        chk("reset res_data",   32'(res_data),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("r0 ordinary", 32'(bank[0]), 32'h0003);

        // Back-to-back dependent ops: r3 is stale in the bank, so only forwarding yields 3.
        load_reg(3'd3, 16'h1234);
        drive(3'd0, 3'd3, 3'd1, 3'd2);
        @(posedge clk); @(negedge clk);
        chk("b2b first data", 32'(res_data), 32'h0008);
        chk("b2b in_ready",   32'(in_ready), 32'd1);
        drive(3'd1, 3'd4, 3'd3, 3'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("b2b no bubble",   32'(res_valid), 32'd1);
        chk("b2b fwd data",    32'(res_data),  32'h0003);
        chk("b2b fwd carry",   32'(res_carry), 32'd0);
        chk("b2b second addr", 32'(rf_waddr),  32'd4);
        @(posedge clk); @(negedge clk);
        exp_retire += 2;
        chk("b2b retire_cnt", 32'(retire_cnt), 32'(exp_retire));
        chk("b2b bank r3",    32'(bank[3]),    32'h0008);
        chk("b2b bank r4",    32'(bank[4]),    32'h0003);

        // Stall for 3 cycles with a dependent op waiting on the pending r6.
        res_ready = 1'b0;
        drive(3'd0, 3'd6, 3'd1, 3'd2);
        @(posedge clk); @(negedge clk);
        drive(3'd1, 3'd7, 3'd6, 3'd1);
        w0 = wr_cnt;
        chk("stall res_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d res_data", i), 32'(res_data), 32'h0008);
            chk($sformatf("stall%0d rf_we", i),    32'(rf_we),    32'd0);
            @(posedge clk); @(negedge clk);
        end
        chk("stall no write", 32'(wr_cnt), 32'(w0));
        chk("stall retire_cnt held", 32'(retire_cnt), 32'(exp_retire));
        res_ready = 1'b1;
        #1;
        chk("release rf_we",    32'(rf_we),    32'd1);
        chk("release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        exp_retire++;
        chk("release one write", 32'(wr_cnt),     32'(w0 + 1));
        chk("release retire",    32'(retire_cnt), 32'(exp_retire));
        chk("stall fwd data",    32'(res_data),   32'h0003);
        @(posedge clk); @(negedge clk);
        exp_retire++;
        chk("stall fwd bank r7", 32'(bank[7]), 32'h0003);

        // Reset asserted mid-stall discards the pending result.
        res_ready = 1'b0;
        drive(3'd0, 3'd2, 3'd1, 3'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset res_valid", 32'(res_valid), 32'd1);
        @(posedge clk); @(negedge clk);
        #2;
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst res_valid",  32'(res_valid),  32'd0);
        chk("midrst retire_cnt", 32'(retire_cnt), 32'd0);
        chk("midrst rf_we",      32'(rf_we),      32'd0);
        chk("midrst in_ready",   32'(in_ready),   32'd1);
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst no write", 32'(wr_cnt),  32'(w0));
        chk("midrst bank r2",  32'(bank[2]), 32'h0003);
        rst_n = 1'b1;
        exp_retire = 0;
        @(negedge clk);

        // Opcode 7 with 0x0100 * 0x0100.
        load_reg(3'd1, 16'h0100);
        load_reg(3'd2, 16'h0100);
`ifdef ALU_WB_MUL_EN
        v7 = '{3'd7, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b1};
`else
        v7 = '{3'd7, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0};
`endif
        run_vec(v7, "op7");
`ifdef ALU_WB_MUL_EN
        chk("op7 bank r5", 32'(bank[5]), 32'h0000);
`else
        chk("op7 bank r5", 32'(bank[5]), 32'hFFFE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
